// File: rtl/lock_pkg.sv
// Shared definitions for the six-digit code lock and its automated dialer.
package lock_pkg;

  // Seven-segment glyphs, active-low, bit 6 = segment g ... bit 0 = segment a
  localparam logic [6:0] SEG_O    = 7'b1000000;
  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_n    = 7'b0101011;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_L    = 7'b1000111;
  localparam logic [6:0] SEG_S    = 7'b0010010;
  localparam logic [6:0] SEG_d    = 7'b0100001;
  localparam logic [6:0] SEG_r    = 7'b0101111;
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  // Lock status as reported by the dialer
  localparam logic [1:0] RES_UNKNOWN = 2'b00;
  localparam logic [1:0] RES_OPEN    = 2'b01;
  localparam logic [1:0] RES_CLOSED  = 2'b10;
  localparam logic [1:0] RES_ERROR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PRESS,
    ST_GAP,
    ST_SETTLE,
    ST_SAMPLE
  } dialer_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_result_decoder.sv
// Maps the lock's six seven-segment displays onto a 2-bit lock status.
// Unused displays must be dark for a pattern to count as a match.
module hex_result_decoder
  import lock_pkg::*;
(
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  input  logic [6:0] hex4,
  input  logic [6:0] hex5,
  output logic [1:0] result
);

  logic [41:0] disp;

  assign disp = {hex5, hex4, hex3, hex2, hex1, hex0};

  // Exact whole-display comparison against the three known messages
  always_comb begin
    result = RES_UNKNOWN;
    if (disp == {SEG_DARK, SEG_DARK, SEG_O, SEG_P, SEG_E, SEG_n}) begin
      result = RES_OPEN;
    end else if (disp == {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_d}) begin
      result = RES_CLOSED;
    end else if (disp == {SEG_DARK, SEG_E, SEG_r, SEG_r, SEG_O, SEG_r}) begin
      result = RES_ERROR;
    end
  end

endmodule

// File: rtl/code_dialer.sv
// Automated code entry for the six-digit lock: resets the lock, plays each
// latched BCD digit with a press strobe, then decodes the lock's displays.
module code_dialer
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned PRESS_CYC  = 1,
  parameter int unsigned GAP_CYC    = 1,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   code,
  input  logic [6:0]            hex0,
  input  logic [6:0]            hex1,
  input  logic [6:0]            hex2,
  input  logic [6:0]            hex3,
  input  logic [6:0]            hex4,
  input  logic [6:0]            hex5,
  output logic [3:0]            dig_out,
  output logic                  press,
  output logic                  lock_rst,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            result
);

  localparam int unsigned CODE_W  = 4 * DIGITS;
  localparam int unsigned CNT_MAX = max_u(max_u(SETUP_CYC, PRESS_CYC),
                                          max_u(GAP_CYC, SETTLE_CYC));
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned SW      = $clog2(DIGITS + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PRESS_LAST  = CW'(PRESS_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SLOT_LAST   = SW'(DIGITS);

  dialer_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        dig_out_q, dig_out_d;
  logic              press_q, press_d;
  logic              lock_rst_q, lock_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        result_q, result_d;
  logic [1:0]        dec_result;
  logic              slot_end;

  hex_result_decoder u_decoder (
    .hex0   (hex0),
    .hex1   (hex1),
    .hex2   (hex2),
    .hex3   (hex3),
    .hex4   (hex4),
    .hex5   (hex5),
    .result (dec_result)
  );

  // Next-state, counters and output values; outputs are derived from the
  // next state so every output leaves a flop aligned with its state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    code_d    = code_q;
    dig_out_d = dig_out_q;
    result_d  = result_q;
    done_d    = 1'b0;
    slot_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          cnt_d     = '0;
          slot_d    = '0;
          code_d    = code;
          dig_out_d = '0;
          result_d  = RES_UNKNOWN;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_PRESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PRESS: begin
        if (cnt_q == PRESS_LAST) begin
          if (GAP_CYC == 0) begin
            slot_end = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          slot_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SAMPLE: begin
        state_d  = ST_IDLE;
        result_d = dec_result;
        done_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Slot wrap-up is shared by PRESS (when GAP is skipped) and GAP; the next
    // digit is taken from the top nibble as the code register shifts left.
    if (slot_end) begin
      cnt_d = '0;
      if (slot_q == SLOT_LAST) begin
        state_d = ST_SETTLE;
      end else begin
        state_d   = ST_SETUP;
        slot_d    = slot_q + SW'(1);
        dig_out_d = code_q[CODE_W-1 -: 4];
        code_d    = code_q << 4;
      end
    end

    press_d    = (state_d == ST_PRESS);
    lock_rst_d = (slot_d == '0) && ((state_d == ST_SETUP) || (state_d == ST_PRESS));
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      code_q     <= '0;
      dig_out_q  <= '0;
      press_q    <= 1'b0;
      lock_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= RES_UNKNOWN;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      code_q     <= code_d;
      dig_out_q  <= dig_out_d;
      press_q    <= press_d;
      lock_rst_q <= lock_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign dig_out  = dig_out_q;
  assign press    = press_q;
  assign lock_rst = lock_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_code_dialer.sv
// Bench for code_dialer: a behavioural lock model answers the dialer,
// directed and random sequences are checked for timing, digits and result,
// and the display decoder is checked from a vector table.
module tb_code_dialer;
  import lock_pkg::*;

  localparam int DIG     = 6;
  localparam int SETUP   = 4;
  localparam int PRESS   = 1;
  localparam int GAP     = 1;
  localparam int SETTLE  = 8;
  localparam int L       = SETUP + PRESS + GAP;
  localparam int DONE_AT = (DIG + 1) * L + SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] code;
  logic [41:0] lk_hex;
  logic [3:0]  dig_out;
  logic        press;
  logic        lock_rst;
  logic        busy;
  logic        done;
  logic [1:0]  result;

  logic [41:0] d_hex;
  logic [1:0]  d_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  code_dialer #(
    .DIGITS     (DIG),
    .SETUP_CYC  (SETUP),
    .PRESS_CYC  (PRESS),
    .GAP_CYC    (GAP),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .code     (code),
    .hex0     (lk_hex[6:0]),
    .hex1     (lk_hex[13:7]),
    .hex2     (lk_hex[20:14]),
    .hex3     (lk_hex[27:21]),
    .hex4     (lk_hex[34:28]),
    .hex5     (lk_hex[41:35]),
    .dig_out  (dig_out),
    .press    (press),
    .lock_rst (lock_rst),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  hex_result_decoder u_dec (
    .hex0   (d_hex[6:0]),
    .hex1   (d_hex[13:7]),
    .hex2   (d_hex[20:14]),
    .hex3   (d_hex[27:21]),
    .hex4   (d_hex[34:28]),
    .hex5   (d_hex[41:35]),
    .result (d_res)
  );

  // Behavioural lock: reset key clears entry, each press edge appends a digit
  logic [23:0] lock_secret;
  logic [23:0] lk_val;
  int          lk_cnt;
  logic        lk_err;
  logic        lk_prev_press;

  always @(posedge clk) begin
    if (lock_rst) begin
      lk_cnt <= 0;
      lk_err <= 1'b0;
      lk_val <= '0;
    end else if (press && !lk_prev_press && lk_cnt < 6) begin
      lk_val <= {lk_val[19:0], dig_out};
      lk_cnt <= lk_cnt + 1;
      if (dig_out > 4'd9) lk_err <= 1'b1;
    end
    lk_prev_press <= press;
  end

  always_comb begin
    lk_hex = {6{SEG_DARK}};
    if (lk_err)
      lk_hex = {SEG_DARK, SEG_E, SEG_r, SEG_r, SEG_O, SEG_r};
    else if (lk_cnt == 6 && lk_val == lock_secret)
      lk_hex = {SEG_DARK, SEG_DARK, SEG_O, SEG_P, SEG_E, SEG_n};
    else if (lk_cnt == 6)
      lk_hex = {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_d};
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected lock status from the code and secret alone
  function automatic logic [1:0] ref_result(input logic [23:0] c, input logic [23:0] s);
    for (int i = 0; i < 6; i++)
      if (c[4*i +: 4] > 4'd9) return 2'b11;
    return (c == s) ? 2'b01 : 2'b10;
  endfunction

  // mode 0: plain run, 1: second start at cycle 20, 2: reset during slot-3
  // press, 3: start held high across done
  task automatic run_seq(input logic [23:0] c, input logic [23:0] secret, input int mode);
    logic [3:0] exp_dig[7];
    logic [1:0] exp_res;
    int press_n, rst_n_cnt, busy_n, done_n;
    logic prev_press;
    logic finished;

    lock_secret = secret;
    exp_dig[0] = 4'd0;
    for (int k = 1; k <= DIG; k++) exp_dig[k] = c[(DIG - k) * 4 +: 4];
    exp_res = ref_result(c, secret);

    @(negedge clk);
    code  = c;
    start = 1'b1;
    press_n = 0; rst_n_cnt = 0; busy_n = 0; done_n = 0;
    prev_press = 1'b0;
    finished = 1'b0;

    for (int cyc = 0; cyc < 160 && !finished; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 0 && mode != 3) start = 1'b0;
      if (mode == 1 && cyc == 19) begin start = 1'b1; code = 24'h999999; end
      if (mode == 1 && cyc == 20) start = 1'b0;

      if (cyc == 0) chk("result_cleared_on_start", result, 0);

      if (cyc <= DONE_AT) begin
        if (cyc % L == 0 && cyc / L <= DIG)
          chk($sformatf("dig_at_setup[%0d]", cyc / L), dig_out, exp_dig[cyc / L]);
        if (press && !prev_press) begin
          if (press_n <= DIG) begin
            chk($sformatf("press_time[%0d]", press_n), cyc, press_n * L + SETUP);
            chk($sformatf("press_digit[%0d]", press_n), dig_out, exp_dig[press_n]);
          end else begin
            chk("extra_press", press_n, DIG);
          end
          press_n++;
        end
        if (lock_rst) begin
          rst_n_cnt++;
          if (cyc >= SETUP + PRESS) chk("lock_rst_late", cyc, SETUP + PRESS - 1);
        end
        if (busy) busy_n++;
      end
      prev_press = press;

      if (mode == 2 && cyc == 3 * L + SETUP) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_press", press, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_lock_rst", lock_rst, 0);
        chk("async_rst_dig_out", dig_out, 0);
        chk("async_rst_result", result, 0);
        for (int j = 0; j < DONE_AT; j++) begin
          @(posedge clk);
          @(negedge clk);
          if (j == 2) rst_n = 1'b1;
          if (done) chk("no_done_after_reset", done, 0);
          if (busy) chk("no_busy_after_reset", busy, 0);
        end
        chk("no_done_after_reset_end", done_n, 0);
        finished = 1'b1;
      end else if (done) begin
        done_n++;
        if (done_n == 1) begin
          chk("done_time", cyc, DONE_AT);
          chk("result", result, exp_res);
          chk("busy_low_at_done", busy, 0);
        end else begin
          chk("done2_time", cyc, 2 * DONE_AT + 1);
          chk("result2", result, exp_res);
        end
        if (mode != 3 || done_n == 2) begin
          finished = 1'b1;
          if (mode == 0) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("result_held", result, exp_res);
          end
        end
      end

      if (mode == 3 && cyc == DONE_AT + 1) begin
        chk("restart_busy", busy, 1);
        start = 1'b0;
      end
    end

    if (mode != 2) begin
      if (!finished) chk("done_timeout", 0, 1);
      chk("press_count", press_n, DIG + 1);
      chk("lock_rst_cycles", rst_n_cnt, SETUP + PRESS);
      chk("busy_cycles", busy_n, DONE_AT);
    end
  endtask

  typedef struct {
    logic [41:0] hex;
    logic [1:0]  exp;
  } dec_vec_t;

  initial begin
    dec_vec_t    vecs[9];
    logic [23:0] sec, c;
    int unsigned r;

    rst_n = 1'b0;
    start = 1'b0;
    code  = '0;
    lock_secret = 24'h550245;
    d_hex = '1;

    // Decoder vector table
    vecs[0] = '{ {6{SEG_DARK}}, 2'b00 };
    vecs[1] = '{ {SEG_DARK, SEG_DARK, SEG_O, SEG_P, SEG_E, SEG_n}, 2'b01 };
    vecs[2] = '{ {SEG_DARK, SEG_E, SEG_O, SEG_P, SEG_E, SEG_n}, 2'b00 };
    vecs[3] = '{ {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_d}, 2'b10 };
    vecs[4] = '{ {SEG_O, SEG_L, SEG_O, SEG_S, SEG_E, SEG_d}, 2'b00 };
    vecs[5] = '{ {SEG_DARK, SEG_E, SEG_r, SEG_r, SEG_O, SEG_r}, 2'b11 };
    vecs[6] = '{ {SEG_C, SEG_E, SEG_r, SEG_r, SEG_O, SEG_r}, 2'b00 };
    vecs[7] = '{ 42'd0, 2'b00 };
    vecs[8] = '{ {SEG_DARK, SEG_DARK, SEG_O, SEG_P, SEG_E, 7'b0101010}, 2'b00 };

    for (int i = 0; i < 9; i++) begin
      d_hex = vecs[i].hex;
      #1;
      chk($sformatf("decoder[%0d]", i), d_res, vecs[i].exp);
    end

    repeat (3) @(negedge clk);
    chk("reset_dig_out", dig_out, 0);
    chk("reset_press", press, 0);
    chk("reset_lock_rst", lock_rst, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(24'h550245, 24'h550245, 0);
    run_seq(24'h450245, 24'h550245, 0);
    run_seq(24'hA50245, 24'h550245, 0);
    run_seq(24'h550245, 24'h550245, 1);
    run_seq(24'h550245, 24'h550245, 2);
    run_seq(24'h550245, 24'h550245, 0);
    run_seq(24'h123456, 24'h123456, 3);

    // Random codes against random secrets, mostly close to the secret
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 6; k++) sec[4*k +: 4] = 4'($urandom_range(0, 9));
      for (int k = 0; k < 6; k++) begin
        r = $urandom_range(0, 11);
        if (r < 8)       c[4*k +: 4] = sec[4*k +: 4];
        else if (r < 11) c[4*k +: 4] = 4'($urandom_range(0, 9));
        else             c[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      if (n == 0) c = sec;
      run_seq(c, sec, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_dialer.md
# code_dialer

Automated initiator for the six-digit code lock: latches a BCD code on `start`, resets the lock, then plays each digit onto the lock's switch inputs with a press strobe, exactly as a user does with SW[3:0] and KEY[0]. After the last digit it decodes the lock's six seven-segment outputs into OPEN / CLOSED / ERROR. It sits beside the lock in self-test builds and serves as a reusable driver in benches.

## Interface
- `DIGITS`, 6: code length in digits.
- `SETUP_CYC`, 4: cycles `dig_out` is stable before `press` rises.
- `PRESS_CYC`, 1: cycles `press` is held high.
- `GAP_CYC`, 1: cycles `press` is low after a press, before the next slot.
- `SETTLE_CYC`, 8: cycles waited after the last slot before sampling the HEX inputs.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a sequence; sampled only in IDLE.
- `code` input 4*DIGITS: digit 0 (entered first) in the MSB nibble; latched on accepted `start`.
- `hex0`..`hex5` input 7 each: lock display outputs, active-low segments.
- `dig_out` output 4: digit presented to the lock's SW[3:0].
- `press` output 1: active-high strobe for the lock's enter key.
- `lock_rst` output 1: active-high request to the lock's reset key.
- `busy` output 1: high from accepted `start` until `done`.
- `done` output 1: one-cycle pulse when `result` is updated.
- `result` output 2: 00 unknown, 01 open, 10 closed, 11 error; held until the next accepted `start`.

## Operation
- States: IDLE, SETUP, PRESS, GAP, SETTLE, SAMPLE.
- IDLE with `start`=1: latch `code`, clear slot index to 0, go to SETUP, `busy`=1, `result`=00.
- A slot is SETUP (SETUP_CYC) -> PRESS (PRESS_CYC) -> GAP (GAP_CYC).
- Slot 0 is the reset slot: `lock_rst`=1 for all of SETUP and PRESS, 0 in GAP; `dig_out`=0.
- Slots 1..DIGITS: `dig_out` = digit (slot-1), `lock_rst`=0.
- After the GAP of slot DIGITS: SETTLE for SETTLE_CYC, then SAMPLE for one cycle.
- `dig_out` changes only on entry to SETUP and is constant through PRESS and GAP.
- Digits 10..15 are sent unmodified, so the lock's error path can be exercised.
- SAMPLE: register decoded `result`, pulse `done`, drop `busy`, return to IDLE.
- Decode, exact 7-bit match (the lock leaves unused displays dark):
  - `hex3..hex0` = O,P,E,n -> 01.
  - `hex5..hex0` = C,L,O,S,E,d -> 10.
  - `hex4..hex0` = E,r,r,O,r -> 11.
  - Anything else -> 00.
- Segment codes:
  - O=1000000, P=0001100, E=0000110, n=0101011
  - C=1000110, L=1000111, S=0010010, d=0100001, r=0101111
- `start` while busy: ignored, and the latched code is unchanged.

## Timing
- Reset values: state IDLE, `dig_out`=0, `press`=0, `lock_rst`=0, `busy`=0, `done`=0, `result`=00.
- Reset mid-sequence: all outputs reach their reset values asynchronously, including an in-progress `press`. No partial result is reported.
- All outputs are registered.
- `busy` rises in the cycle after the edge that samples `start`.
- Slot length L = SETUP_CYC+PRESS_CYC+GAP_CYC.
- `done` rises (DIGITS+1)*L + SETTLE_CYC + 1 cycles after the start-sampling edge. With defaults this is 51 cycles.
- `start` held high continuously: a new sequence begins in the cycle after `done`.
- Each counter is wide enough for its parameter. Parameters equal to 0 other than GAP_CYC are illegal; GAP_CYC=0 skips GAP.

## Structure
- Shared package `lock_pkg`:
  - seven-segment constants (O,P,E,n,C,L,S,d,r);
  - result encoding (RES_UNKNOWN, RES_OPEN, RES_CLOSED, RES_ERROR);
  - the dialer state enum.
- Sub-module `hex_result_decoder`: purely combinational, hex0..hex5 -> 2-bit result, reusable by the lock's own bench.
- The top module holds the FSM, the slot, phase and digit counters, and the code shift register (left shift by 4 per digit slot).

## Test plan
- Code 550245 against a lock programmed with 550245 -> `dig_out` sequence 0(reset),5,5,0,2,4,5 with one `press` per slot; `result`=01, `done` at cycle 51.
- Code 450245 -> `result`=10 (CLOSED) after the full six digits.
- Code with digit 0 = 10 (0xA50245) -> lock shows ErrOr, `result`=11. All 6 digit slots are still played.
- `start` pulsed again at cycle 20 with code 999999 -> ignored; the 550245 sequence and result are unchanged.
- `rst_n` low during PRESS of slot 3 -> `press`, `busy`, `lock_rst` low immediately, no `done`. A new start then completes normally with `result`=01.
- Decoder alone: all-dark HEX (1111111) -> 00; OPEN pattern with hex4 ≠ 1111111 -> 00.
